// File: rtl/exec_logic_unit.sv
// Multi-cycle logic/shift execution unit: bitwise ops complete in one edge,
// shifts iterate one bit per cycle, and the result is held until writeback takes it.
module exec_logic_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [4:0]       shamt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_XOR = 3'b010;
   localparam logic [2:0] OP_NOR = 3'b011;
   localparam logic [2:0] OP_SRL = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_SRA = 3'b110;
   localparam logic [2:0] OP_ILL = 3'b111;

   state_t           state_reg, state_next;
   logic [4:0]       count_reg, count_next;
   logic [2:0]       op_reg, op_next;
   logic [WIDTH-1:0] result_reg, result_next;
   logic             illegal_reg, illegal_next;

   logic             accept;
   logic             fill_bit;
   logic [WIDTH-1:0] shift_right;
   logic [WIDTH-1:0] shift_left;
   logic [WIDTH-1:0] shift_one;

   // in_ready is masked by rst so the issue stage never sees a ready block during reset.
   assign in_ready = (state_reg == IDLE) && !rst;
   assign accept   = in_valid && in_ready;

   // SRA replicates the current sign bit each step; SRL fills with zero.
   assign fill_bit = (op_reg == OP_SRA) ? result_reg[WIDTH-1] : 1'b0;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift_bit
         if (gi == WIDTH - 1) begin : g_msb
            assign shift_right[gi] = fill_bit;
         end else begin : g_mid_r
            assign shift_right[gi] = result_reg[gi+1];
         end
         if (gi == 0) begin : g_lsb
            assign shift_left[gi] = 1'b0;
         end else begin : g_mid_l
            assign shift_left[gi] = result_reg[gi-1];
         end
      end
   endgenerate

   assign shift_one = (op_reg == OP_SLL) ? shift_left : shift_right;

   always_comb begin
      state_next   = state_reg;
      count_next   = count_reg;
      op_next      = op_reg;
      result_next  = result_reg;
      illegal_next = illegal_reg;

      case (state_reg)
         IDLE: begin
            if (accept) begin
               op_next      = op;
               illegal_next = 1'b0;
               count_next   = 5'd0;
               state_next   = DONE;
               case (op)
                  OP_AND: result_next = in1 & in2;
                  OP_OR:  result_next = in1 | in2;
                  OP_XOR: result_next = in1 ^ in2;
                  OP_NOR: result_next = ~(in1 | in2);
                  OP_SRL, OP_SLL, OP_SRA: begin
                     result_next = in1;
                     if (shamt != 5'd0) begin
                        count_next = shamt;
                        state_next = SHIFT;
                     end
                  end
                  OP_ILL: begin
                     result_next  = '0;
                     illegal_next = 1'b1;
                  end
                  default: result_next = '0;
               endcase
            end
         end

         SHIFT: begin
            result_next = shift_one;
            count_next  = count_reg - 5'd1;
            if (count_reg == 5'd1) begin
               state_next = DONE;
            end
         end

         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end

         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         count_reg   <= 5'd0;
         op_reg      <= OP_AND;
         result_reg  <= '0;
         illegal_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         count_reg   <= count_next;
         op_reg      <= op_next;
         result_reg  <= result_next;
         illegal_reg <= illegal_next;
      end
   end

   assign out_valid = (state_reg == DONE);
   assign result    = result_reg;
   assign zero      = (result_reg == '0);
   assign illegal   = illegal_reg;

endmodule

// File: tb/tb_exec_logic_unit.sv
// Randomised self-checking bench for exec_logic_unit against an arithmetic reference model.
module tb_exec_logic_unit;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    op;
   logic [W-1:0]  in1;
   logic [W-1:0]  in2;
   logic [4:0]    shamt;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  result;
   logic          zero;
   logic          illegal;

   int errors = 0;
   int checks = 0;

   exec_logic_unit #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .in1       (in1),
      .in2       (in2),
      .shamt     (shamt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   // Reference: what the operation means, independent of how many cycles it takes.
   function automatic logic [W-1:0] model_result(input logic [2:0] o, input logic [W-1:0] a,
                                                 input logic [W-1:0] b, input logic [4:0] s);
      case (o)
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b010:  return a ^ b;
         3'b011:  return ~(a | b);
         3'b100:  return a >> s;
         3'b101:  return a << s;
         3'b110:  return W'($signed(a) >>> s);
         default: return '0;
      endcase
   endfunction

   function automatic int model_latency(input logic [2:0] o, input logic [4:0] s);
      if ((o == 3'b100 || o == 3'b101 || o == 3'b110) && s != 5'd0) return int'(s) + 1;
      return 1;
   endfunction

   task automatic scramble_inputs();
      op    = 3'($urandom);
      in1   = $urandom;
      in2   = $urandom;
      shamt = 5'($urandom);
   endtask

   // Accept one op and count edges until out_valid; inputs are scrambled while busy.
   task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] s, output int lat);
      for (int w = 0; w < 10 && !in_ready; w++) begin
         @(posedge clk); #1;
      end
      op = o; in1 = a; in2 = b; shamt = s; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         scramble_inputs();
         in_valid = $urandom_range(0, 1);
         @(posedge clk); #1;
         lat++;
      end
      in_valid = 1'b0;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      op = '0; in1 = '0; in2 = '0; shamt = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (result !== '0 || out_valid !== 1'b0 || illegal !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold: result=%h out_valid=%b illegal=%b in_ready=%b, want 0/0/0/0",
                  result, out_valid, illegal, in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: in_ready=%b, want 1", in_ready);
      end
      $display("reset: in_ready=%b after release", in_ready);
   endtask

   task automatic test_and();
      int lat;
      issue(3'b000, 32'hFFFF0000, 32'h0F0F0F0F, 5'd0, lat);
      checks++;
      if (lat !== 1 || result !== 32'h0F0F0000 || zero !== 1'b0 || illegal !== 1'b0) begin
         errors++;
         $display("FAIL and_basic: lat=%0d result=%h zero=%b illegal=%b, want 1 0f0f0000 0 0",
                  lat, result, zero, illegal);
      end
      $display("and: lat=%0d result=%h", lat, result);
      handshake();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL and_handshake: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_srl_sra();
      int lat;
      issue(3'b100, 32'h80000000, 32'h0, 5'd31, lat);
      checks++;
      if (lat !== 32 || result !== 32'h00000001) begin
         errors++;
         $display("FAIL srl_31: lat=%0d result=%h, want 32 00000001", lat, result);
      end
      $display("srl31: lat=%0d result=%h", lat, result);
      handshake();
      issue(3'b110, 32'h80000000, 32'h0, 5'd31, lat);
      checks++;
      if (lat !== 32 || result !== 32'hFFFFFFFF || zero !== 1'b0) begin
         errors++;
         $display("FAIL sra_31: lat=%0d result=%h zero=%b, want 32 ffffffff 0", lat, result, zero);
      end
      $display("sra31: lat=%0d result=%h", lat, result);
      handshake();
   endtask

   task automatic test_sll_zero_xor();
      int lat;
      issue(3'b101, 32'h12345678, 32'hDEADBEEF, 5'd0, lat);
      checks++;
      if (lat !== 1 || result !== 32'h12345678) begin
         errors++;
         $display("FAIL sll_0: lat=%0d result=%h, want 1 12345678", lat, result);
      end
      $display("sll0: lat=%0d result=%h", lat, result);
      handshake();
      issue(3'b010, 32'hA5A5A5A5, 32'hA5A5A5A5, 5'd7, lat);
      checks++;
      if (lat !== 1 || result !== 32'h0 || zero !== 1'b1) begin
         errors++;
         $display("FAIL xor_zero: lat=%0d result=%h zero=%b, want 1 00000000 1", lat, result, zero);
      end
      $display("xor: lat=%0d result=%h zero=%b", lat, result, zero);
      handshake();
   endtask

   task automatic test_backpressure();
      int lat;
      logic [W-1:0] a, b, exp;
      a = $urandom; b = $urandom;
      exp = model_result(3'b001, a, b, 5'd0);
      issue(3'b001, a, b, 5'd3, lat);
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1;
         scramble_inputs();
         @(posedge clk); #1;
         checks++;
         if (result !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_hold: cycle=%0d result=%h out_valid=%b in_ready=%b, want %h 1 0",
                     c, result, out_valid, in_ready, exp);
         end
      end
      in_valid = 1'b0;
      handshake();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL backpressure_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
      end
      $display("backpressure: held result=%h, released", exp);
   endtask

   task automatic test_reset_mid_shift();
      int lat;
      int spurious;
      logic [W-1:0] a, b;
      op = 3'b101; in1 = $urandom; in2 = '0; shamt = 5'd10; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (result !== '0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_shift: result=%h out_valid=%b in_ready=%b, want 0 0 0",
                  result, out_valid, in_ready);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      spurious = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (out_valid) spurious++;
      end
      checks++;
      if (spurious !== 0) begin
         errors++;
         $display("FAIL reset_no_pulse: out_valid cycles=%0d, want 0", spurious);
      end
      a = $urandom; b = $urandom;
      issue(3'b001, a, b, 5'd0, lat);
      checks++;
      if (lat !== 1 || result !== (a | b)) begin
         errors++;
         $display("FAIL reset_then_or: lat=%0d result=%h, want 1 %h", lat, result, a | b);
      end
      $display("reset_mid_shift: aborted, then or result=%h", result);
      handshake();
   endtask

   task automatic test_illegal_nor();
      int lat;
      issue(3'b111, 32'h12345678, 32'h87654321, 5'd9, lat);
      checks++;
      if (lat !== 1 || illegal !== 1'b1 || result !== '0 || zero !== 1'b1) begin
         errors++;
         $display("FAIL illegal_op: lat=%0d illegal=%b result=%h zero=%b, want 1 1 0 1",
                  lat, illegal, result, zero);
      end
      $display("illegal: illegal=%b result=%h", illegal, result);
      handshake();
      issue(3'b011, 32'h0, 32'h0, 5'd0, lat);
      checks++;
      if (lat !== 1 || illegal !== 1'b0 || result !== 32'hFFFFFFFF) begin
         errors++;
         $display("FAIL nor_after_illegal: lat=%0d illegal=%b result=%h, want 1 0 ffffffff",
                  lat, illegal, result);
      end
      $display("nor: result=%h illegal=%b", result, illegal);
      handshake();
   endtask

   task automatic test_random();
      int lat;
      int exp_lat;
      logic [2:0] o;
      logic [W-1:0] a, b, exp;
      logic [4:0] s;
      for (int n = 0; n < 60; n++) begin
         o = 3'($urandom); a = $urandom; b = $urandom; s = 5'($urandom);
         if (n % 7 == 0) b = a;
         exp = model_result(o, a, b, s);
         exp_lat = model_latency(o, s);
         issue(o, a, b, s, lat);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
         checks++;
         if (lat !== exp_lat || result !== exp || zero !== (exp == '0) ||
             illegal !== (o == 3'b111) || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL random_op: n=%0d op=%0d s=%0d lat=%0d result=%h zero=%b ill=%b, want lat=%0d %h",
                     n, o, s, lat, result, zero, illegal, exp_lat, exp);
         end
         $display("random n=%0d op=%0d in1=%h in2=%h s=%0d -> %h lat=%0d", n, o, a, b, s, result, lat);
         handshake();
      end
   endtask

   initial begin
      test_reset();
      test_and();
      test_srl_sra();
      test_sll_zero_xor();
      test_backpressure();
      test_reset_mid_shift();
      test_illegal_nor();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
